// File: rtl/lv_hv_pkg.sv
// Shared definitions for the HV pwm_intb encoder and its paired LV decoder.
// Holds the encoder FSM state type, the pulse-count code for intb
// assert/release, and the decoder's pulse-width / frame-close thresholds.
package lv_hv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_GUARD = 2'd3
    } pwm_intb_state_e;

    // Pulse count per frame: one pulse = intb asserted, three = released.
    localparam int unsigned PWM_INTB_ASSERT_PULSES  = 1;
    localparam int unsigned PWM_INTB_RELEASE_PULSES = 3;

    // LV decoder accepts pulses 4..12 cycles wide and closes a frame after
    // more than 12 quiet cycles.
    localparam int unsigned PWM_INTB_DEC_MIN_CYC = 4;
    localparam int unsigned PWM_INTB_DEC_MAX_CYC = 12;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/gnrl_sync.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: i_clk, i_rst_n (async active-low), i_d (async input),
//        o_q (synchronised level, RST_VAL while in reset).
module gnrl_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= RST_VAL;
            o_q    <= RST_VAL;
        end else begin
            meta_q <= i_d;
            o_q    <= meta_q;
        end
    end

endmodule

// File: rtl/hv_pwm_intb_encode.sv
// HV-side encoder: multiplexes the HV interrupt level onto the pwm_intb_n
// isolation channel that otherwise carries the PWM gate wave. Each change of
// intb_n is sent as a burst of inverted pulses (1 = asserted, 3 = released)
// followed by a quiet guard window.
// Ports: i_clk, i_rst_n (async active-low), i_pwm_gwave (gate wave, sync),
//        i_intb_n (HV interrupt, async), o_hv_pwm_intb_n (encoded channel),
//        o_busy (frame in progress), o_frame_done (last guard cycle).
module hv_pwm_intb_encode
    import lv_hv_pkg::*;
#(
    parameter int unsigned PULSE_CYC  = 8,
    parameter int unsigned GAP_CYC    = 8,
    parameter int unsigned GUARD_CYC  = 16,
    parameter int unsigned STABLE_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pwm_gwave,
    input  logic i_intb_n,
    output logic o_hv_pwm_intb_n,
    output logic o_busy,
    output logic o_frame_done
);

    localparam int unsigned CNT_W = $clog2(max4(PULSE_CYC, GAP_CYC, GUARD_CYC, STABLE_CYC) + 1);

    // Parameter legality against the LV decoder thresholds (elaboration only).
    if (PULSE_CYC <= PWM_INTB_DEC_MIN_CYC || PULSE_CYC >= PWM_INTB_DEC_MAX_CYC) begin : g_bad_pulse
        $error("hv_pwm_intb_encode: PULSE_CYC out of range");
    end
    if (GAP_CYC <= PWM_INTB_DEC_MIN_CYC || GAP_CYC >= PWM_INTB_DEC_MAX_CYC) begin : g_bad_gap
        $error("hv_pwm_intb_encode: GAP_CYC out of range");
    end
    if (GUARD_CYC < PWM_INTB_DEC_MAX_CYC + 2) begin : g_bad_guard
        $error("hv_pwm_intb_encode: GUARD_CYC too small");
    end
    if (STABLE_CYC < PWM_INTB_DEC_MAX_CYC + 2) begin : g_bad_stable
        $error("hv_pwm_intb_encode: STABLE_CYC too small");
    end

    logic intb_s;

    gnrl_sync #(
        .RST_VAL (1'b1)
    ) u_intb_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_intb_n),
        .o_q     (intb_s)
    );

    // Gate-wave stability: cleared on any edge, saturates at STABLE_CYC.
    logic             gw_prev_q;
    logic [CNT_W-1:0] gw_cnt_q, gw_cnt_d;
    logic             gw_stable;

    always_comb begin
        gw_cnt_d = gw_cnt_q;
        if (i_pwm_gwave != gw_prev_q) begin
            gw_cnt_d = '0;
        end else if (gw_cnt_q != CNT_W'(STABLE_CYC)) begin
            gw_cnt_d = gw_cnt_q + CNT_W'(1);
        end
    end

    assign gw_stable = (gw_cnt_q == CNT_W'(STABLE_CYC));

    pwm_intb_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pcnt_q, pcnt_d;
    logic [1:0]       npulse_q, npulse_d;
    logic             gw_lat_q, gw_lat_d;
    logic             tgt_lvl_q, tgt_lvl_d;
    logic             sent_lvl_q, sent_lvl_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        pcnt_d     = pcnt_q;
        npulse_d   = npulse_q;
        gw_lat_d   = gw_lat_q;
        tgt_lvl_d  = tgt_lvl_q;
        sent_lvl_d = sent_lvl_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (intb_s != sent_lvl_q && gw_stable) begin
                    state_d   = ST_PULSE;
                    cnt_d     = CNT_W'(1);
                    pcnt_d    = 2'(1);
                    gw_lat_d  = i_pwm_gwave;
                    tgt_lvl_d = intb_s;
                    npulse_d  = intb_s ? 2'(PWM_INTB_RELEASE_PULSES) : 2'(PWM_INTB_ASSERT_PULSES);
                end
            end
            ST_PULSE: begin
                if (cnt_q == CNT_W'(PULSE_CYC)) begin
                    cnt_d = CNT_W'(1);
                    if (pcnt_q < npulse_q) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d    = ST_GUARD;
                        sent_lvl_d = tgt_lvl_q;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC)) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNT_W'(1);
                    pcnt_d  = pcnt_q + 2'(1);
                end
            end
            ST_GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CYC)) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Channel follows the gate wave only in IDLE; frames use the latched level.
        case (state_q)
            ST_PULSE:         out_d = ~gw_lat_q;
            ST_GAP, ST_GUARD: out_d = gw_lat_q;
            default:          out_d = i_pwm_gwave;
        endcase

        // Status registered from next state so it lines up with the FSM state.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_GUARD) && (cnt_d == CNT_W'(GUARD_CYC));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gw_prev_q  <= 1'b0;
            gw_cnt_q   <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pcnt_q     <= '0;
            npulse_q   <= '0;
            gw_lat_q   <= 1'b0;
            tgt_lvl_q  <= 1'b1;
            sent_lvl_q <= 1'b1;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            gw_prev_q  <= i_pwm_gwave;
            gw_cnt_q   <= gw_cnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            npulse_q   <= npulse_d;
            gw_lat_q   <= gw_lat_d;
            tgt_lvl_q  <= tgt_lvl_d;
            sent_lvl_q <= sent_lvl_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_hv_pwm_intb_n = out_q;
    assign o_busy          = busy_q;
    assign o_frame_done    = done_q;

endmodule

// File: tb/tb_hv_pwm_intb_encode.sv
// Directed self-checking bench for hv_pwm_intb_encode. Expected per-cycle
// output/busy/done samples are queued when stimulus is driven and compared
// on falling clock edges as the DUT produces them.
module tb_hv_pwm_intb_encode;

    localparam int PULSE = 8;
    localparam int GAP   = 8;
    localparam int GUARD = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic gwave;
    logic intb_n;
    logic out;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    hv_pwm_intb_encode dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_pwm_gwave     (gwave),
        .i_intb_n        (intb_n),
        .o_hv_pwm_intb_n (out),
        .o_busy          (busy),
        .o_frame_done    (done)
    );

    typedef struct packed {
        logic out;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_smp  = 0;

    task automatic push(input int n, input logic o, input logic b, input logic d);
        exp_t e;
        e.out  = o;
        e.busy = b;
        e.done = d;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // One frame seen from the cycle after the trigger: `lead` idle samples,
    // then busy with np inverted pulses, guard, done, one trailing idle sample.
    task automatic push_frame(input logic g, input int np, input int lead);
        push(lead, g, 1'b0, 1'b0);
        push(1, g, 1'b1, 1'b0);
        for (int p = 1; p <= np; p++) begin
            push(PULSE, ~g, 1'b1, 1'b0);
            if (p < np) push(GAP, g, 1'b1, 1'b0);
        end
        push(GUARD - 2, g, 1'b1, 1'b0);
        push(1, g, 1'b1, 1'b1);
        push(1, g, 1'b0, 1'b0);
    endtask

    task automatic check_now();
        exp_t e;
        n_smp++;
        if (exp_q.size() == 0) begin
            n_chk++;
            $error("FAIL scoreboard_empty sample=%0d", n_smp);
            return;
        end
        e = exp_q.pop_front();
        n_chk++;
        assert (out === e.out) begin n_pass++; end
        else $error("FAIL out sample=%0d got=%b exp=%b", n_smp, out, e.out);
        n_chk++;
        assert (busy === e.busy) begin n_pass++; end
        else $error("FAIL busy sample=%0d got=%b exp=%b", n_smp, busy, e.busy);
        n_chk++;
        assert (done === e.done) begin n_pass++; end
        else $error("FAIL frame_done sample=%0d got=%b exp=%b", n_smp, done, e.done);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_now();
        end
    endtask

    task automatic drain_all();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check_now();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        gwave  = 1'b1;
        intb_n = 1'b1;

        // Reset values.
        #12;
        push(1, 1'b0, 1'b0, 1'b0);
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        push(30, 1'b1, 1'b0, 1'b0);
        drain_all();

        // Assert frame: one inverted pulse.
        intb_n = 1'b0;
        push_frame(1'b1, 1, 2);
        drain_all();
        push(5, 1'b1, 1'b0, 1'b0);
        drain_all();

        // Release frame: three inverted pulses.
        intb_n = 1'b1;
        push_frame(1'b1, 3, 2);
        drain_all();
        push(5, 1'b1, 1'b0, 1'b0);
        drain_all();

        // Unstable gate wave holds off an assert frame.
        gwave = 1'b0;
        push(1, 1'b0, 1'b0, 1'b0);
        drain_all();
        intb_n = 1'b0;
        push(9, 1'b0, 1'b0, 1'b0);
        drain_all();
        gwave = 1'b1;
        push(10, 1'b1, 1'b0, 1'b0);
        drain_all();
        gwave = 1'b0;
        push(15, 1'b0, 1'b0, 1'b0);
        push_frame(1'b0, 1, 2);
        drain_all();

        // Gate-wave edge mid release frame: deferred, then blocks next frame.
        intb_n = 1'b1;
        push_frame(1'b0, 3, 2);
        drain(50);
        gwave = 1'b1;
        drain_all();
        intb_n = 1'b0;
        push(6, 1'b1, 1'b0, 1'b0);
        push_frame(1'b1, 1, 2);
        drain_all();

        // Short intb glitch during a release frame: no extra frame.
        intb_n = 1'b1;
        push_frame(1'b1, 3, 2);
        drain(10);
        intb_n = 1'b0;
        drain(3);
        intb_n = 1'b1;
        drain_all();
        push(20, 1'b1, 1'b0, 1'b0);
        drain_all();

        // Level that changes and stays during a release frame: new frame after it.
        intb_n = 1'b0;
        push_frame(1'b1, 1, 2);
        drain_all();
        push(3, 1'b1, 1'b0, 1'b0);
        drain_all();
        intb_n = 1'b1;
        push_frame(1'b1, 3, 2);
        drain(30);
        intb_n = 1'b0;
        drain_all();
        push_frame(1'b1, 1, 0);
        drain_all();

        // Reset during PULSE, then a full assert frame after release.
        intb_n = 1'b1;
        push_frame(1'b1, 3, 2);
        drain(6);
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        push(1, 1'b0, 1'b0, 1'b0);
        check_now();
        @(negedge clk);
        intb_n = 1'b0;
        push(2, 1'b0, 1'b0, 1'b0);
        drain(2);
        rst_n = 1'b1;
        push(15, 1'b1, 1'b0, 1'b0);
        push_frame(1'b1, 1, 2);
        drain_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
